// File: rtl/tutorial_io_pkg.sv
// Shared constants for the tutorial board I/O blocks.
// Blinker rate counts and switch debounce timing share one 25 kHz clock basis.
package tutorial_io_pkg;

   localparam int c_CLOCK_HZ = 25_000;

   // Blinker toggle counts: half-period in clock cycles at c_CLOCK_HZ
   localparam int c_CNT_100HZ = 125;
   localparam int c_CNT_50HZ  = 250;
   localparam int c_CNT_10HZ  = 1250;
   localparam int c_CNT_1HZ   = 12500;

   // 10 ms stability window at c_CLOCK_HZ
   localparam int c_DEBOUNCE_CNT = 250;

   typedef enum logic {
      STABLE  = 1'b0,
      PENDING = 1'b1
   } deb_state_t;

endpackage

// File: rtl/tutorial_debounce_channel.sv
// One switch channel: 2-FF synchroniser, stability counter and
// registered rise/fall pulse generator.
module tutorial_debounce_channel
   import tutorial_io_pkg::*;
#(
   parameter int c_DEBOUNCE_CNT = tutorial_io_pkg::c_DEBOUNCE_CNT
) (
   input  logic i_clock,
   input  logic i_reset_n,
   input  logic i_switch,
   output logic o_switch,
   output logic o_rise,
   output logic o_fall,
   output logic o_accept
);

   localparam int c_CNT_W = $clog2(c_DEBOUNCE_CNT);
   localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(c_DEBOUNCE_CNT - 1);

   logic               sync1;
   logic               sync2;
   logic [c_CNT_W-1:0] cnt;
   logic [c_CNT_W-1:0] cnt_nxt;
   logic               level_nxt;
   logic               rise_nxt;
   logic               fall_nxt;
   deb_state_t         state;

   always_ff @(posedge i_clock or negedge i_reset_n) begin
      if (!i_reset_n) begin
         sync1    <= 1'b0;
         sync2    <= 1'b0;
         cnt      <= '0;
         o_switch <= 1'b0;
         o_rise   <= 1'b0;
         o_fall   <= 1'b0;
      end else begin
         sync1    <= i_switch;
         sync2    <= sync1;
         cnt      <= cnt_nxt;
         o_switch <= level_nxt;
         o_rise   <= rise_nxt;
         o_fall   <= fall_nxt;
      end
   end

   // State is implied by whether the synchronised input disagrees with the level
   always_comb begin
      state     = (sync2 != o_switch) ? PENDING : STABLE;
      cnt_nxt   = '0;
      level_nxt = o_switch;
      rise_nxt  = 1'b0;
      fall_nxt  = 1'b0;
      unique case (state)
         STABLE: cnt_nxt = '0;
         PENDING: begin
            if (cnt == c_LAST) begin
               level_nxt = sync2;
               rise_nxt  = sync2;
               fall_nxt  = !sync2;
            end else begin
               cnt_nxt = cnt + c_CNT_W'(1);
            end
         end
         default: cnt_nxt = '0;
      endcase
   end

   assign o_accept = rise_nxt | fall_nxt;

endmodule

// File: rtl/tutorial_switch_debounce.sv
// Multi-channel switch debouncer: clean levels plus one-cycle
// edge pulses for the blinker's enable and rate-select inputs.
module tutorial_switch_debounce
   import tutorial_io_pkg::*;
#(
   parameter int c_NUM_SWITCH   = 3,
   parameter int c_DEBOUNCE_CNT = tutorial_io_pkg::c_DEBOUNCE_CNT
) (
   input  logic                    i_clock,
   input  logic                    i_reset_n,
   input  logic [c_NUM_SWITCH-1:0] i_switch,
   output logic [c_NUM_SWITCH-1:0] o_switch,
   output logic [c_NUM_SWITCH-1:0] o_rise,
   output logic [c_NUM_SWITCH-1:0] o_fall,
   output logic                    o_changed
);

   logic [c_NUM_SWITCH-1:0] accept;

   for (genvar n = 0; n < c_NUM_SWITCH; n++) begin : g_ch
      tutorial_debounce_channel #(
         .c_DEBOUNCE_CNT(c_DEBOUNCE_CNT)
      ) u_ch (
         .i_clock  (i_clock),
         .i_reset_n(i_reset_n),
         .i_switch (i_switch[n]),
         .o_switch (o_switch[n]),
         .o_rise   (o_rise[n]),
         .o_fall   (o_fall[n]),
         .o_accept (accept[n])
      );
   end

   // Registered from the same next-state strobes, so it aligns with the pulses
   always_ff @(posedge i_clock or negedge i_reset_n) begin
      if (!i_reset_n) begin
         o_changed <= 1'b0;
      end else begin
         o_changed <= |accept;
      end
   end

endmodule

// File: tb/tb_tutorial_switch_debounce.sv
// Directed bench for tutorial_switch_debounce: short-window instance
// for the detailed sequence, default-window instance for timing.
module tb_tutorial_switch_debounce;

   logic       i_clock = 1'b0;
   logic       rst_n   = 1'b0;
   logic [2:0] sw      = 3'b000;
   logic [2:0] o_switch;
   logic [2:0] o_rise;
   logic [2:0] o_fall;
   logic       o_changed;

   logic [2:0] sw_d = 3'b000;
   logic [2:0] o_switch_d;
   logic [2:0] o_rise_d;
   logic [2:0] o_fall_d;
   logic       o_changed_d;

   int errors = 0;
   int checks = 0;
   logic seen;

   always #5 i_clock = ~i_clock;

   tutorial_switch_debounce #(
      .c_NUM_SWITCH  (3),
      .c_DEBOUNCE_CNT(4)
   ) dut (
      .i_clock  (i_clock),
      .i_reset_n(rst_n),
      .i_switch (sw),
      .o_switch (o_switch),
      .o_rise   (o_rise),
      .o_fall   (o_fall),
      .o_changed(o_changed)
   );

   tutorial_switch_debounce dut_def (
      .i_clock  (i_clock),
      .i_reset_n(rst_n),
      .i_switch (sw_d),
      .o_switch (o_switch_d),
      .o_rise   (o_rise_d),
      .o_fall   (o_fall_d),
      .o_changed(o_changed_d)
   );

   task automatic step(input int n);
      repeat (n) begin
         @(posedge i_clock);
         #1;
      end
   endtask

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_all(input string tag, input logic [2:0] sw_e,
                          input logic [2:0] r_e, input logic [2:0] f_e,
                          input logic c_e);
      chk({tag, ".switch"}, 32'(o_switch), 32'(sw_e));
      chk({tag, ".rise"}, 32'(o_rise), 32'(r_e));
      chk({tag, ".fall"}, 32'(o_fall), 32'(f_e));
      chk({tag, ".changed"}, 32'(o_changed), 32'(c_e));
   endtask

   initial begin
      logic [2:0] bounce [16];

      // reset
      step(3);
      chk_all("reset", 3'b000, 3'b000, 3'b000, 1'b0);
      chk("reset.def", 32'(o_switch_d), 32'h0);
      rst_n = 1'b1;
      step(2);

      // single rise on bit 1: visible after edge k+5
      sw = 3'b010;
      step(4);
      chk("rise1.k3", 32'(o_switch), 32'h0);
      step(1);
      chk_all("rise1.k4", 3'b000, 3'b000, 3'b000, 1'b0);
      step(1);
      chk_all("rise1.k5", 3'b010, 3'b010, 3'b000, 1'b1);
      step(1);
      chk_all("rise1.k6", 3'b010, 3'b000, 3'b000, 1'b0);

      // bounce on bit 0
      for (int i = 0; i < 16; i++) bounce[i] = 3'b010;
      bounce[0] = 3'b011; bounce[1] = 3'b011;
      bounce[4] = 3'b011; bounce[5] = 3'b011;
      seen = 1'b0;
      for (int i = 0; i < 16; i++) begin
         sw = bounce[i];
         step(1);
         seen = seen | (|o_rise) | (|o_fall) | o_changed;
      end
      chk("bounce.pulse", 32'(seen), 32'h0);
      chk("bounce.switch", 32'(o_switch), 32'h2);

      // release on bit 2
      sw = 3'b110;
      step(7);
      chk("rel.setup", 32'(o_switch), 32'h6);
      sw = 3'b010;
      step(5);
      chk_all("rel.k4", 3'b110, 3'b000, 3'b000, 1'b0);
      step(1);
      chk_all("rel.k5", 3'b010, 3'b000, 3'b100, 1'b1);
      step(1);
      chk_all("rel.k6", 3'b010, 3'b000, 3'b000, 1'b0);

      // simultaneous rise
      sw = 3'b000;
      step(7);
      chk("sim.setup", 32'(o_switch), 32'h0);
      sw = 3'b111;
      step(5);
      chk("sim.k4", 32'(o_switch), 32'h0);
      step(1);
      chk_all("sim.k5", 3'b111, 3'b111, 3'b000, 1'b1);
      step(1);
      chk_all("sim.k6", 3'b111, 3'b000, 3'b000, 1'b0);

      // reset mid-count: bits 2:1 pending fall with counter at 2
      sw = 3'b001;
      step(4);
      rst_n = 1'b0;
      #2;
      chk_all("rst.async", 3'b000, 3'b000, 3'b000, 1'b0);
      step(2);
      rst_n = 1'b1;
      step(5);
      chk_all("rst.rel5", 3'b000, 3'b000, 3'b000, 1'b0);
      step(1);
      chk_all("rst.rel6", 3'b001, 3'b001, 3'b000, 1'b1);
      step(1);
      chk_all("rst.rel7", 3'b001, 3'b000, 3'b000, 1'b0);

      // default window: change after exactly 252 edges
      sw_d = 3'b001;
      step(251);
      chk("def.k250", 32'(o_switch_d), 32'h0);
      step(1);
      chk("def.k251.sw", 32'(o_switch_d), 32'h1);
      chk("def.k251.rise", 32'(o_rise_d), 32'h1);
      chk("def.k251.chg", 32'(o_changed_d), 32'h1);
      step(1);
      chk("def.k252.rise", 32'(o_rise_d), 32'h0);

      // 249-cycle glitch is rejected
      seen = 1'b0;
      sw_d = 3'b000;
      for (int i = 0; i < 249; i++) begin
         step(1);
         seen = seen | (|o_rise_d) | (|o_fall_d) | o_changed_d;
      end
      sw_d = 3'b001;
      for (int i = 0; i < 20; i++) begin
         step(1);
         seen = seen | (|o_rise_d) | (|o_fall_d) | o_changed_d;
      end
      chk("glitch.pulse", 32'(seen), 32'h0);
      chk("glitch.switch", 32'(o_switch_d), 32'h1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
